// File: rtl/muldiv_pkg.sv
// Shared encodings and operand decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MULDIV_MUL    = 3'b000,
      MULDIV_MULH   = 3'b001,
      MULDIV_MULHSU = 3'b010,
      MULDIV_MULHU  = 3'b011,
      MULDIV_DIV    = 3'b100,
      MULDIV_DIVU   = 3'b101,
      MULDIV_REM    = 3'b110,
      MULDIV_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic is_rem(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

   function automatic logic op1_signed(input logic [2:0] op);
      return (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
             (op == MULDIV_DIV)  || (op == MULDIV_REM);
   endfunction

   function automatic logic op2_signed(input logic [2:0] op);
      return (op == MULDIV_MULH) || (op == MULDIV_DIV) || (op == MULDIV_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath on a {hi, lo} accumulator.
// Multiply: lo holds the remaining multiplier bits, hi the running partial product.
// Divide:   hi holds the partial remainder, lo the dividend bits shifting into quotient.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                i_div,
   input  logic [XLEN-1:0]     i_opb,
   input  logic [2*XLEN-1:0]   i_acc,
   output logic [2*XLEN-1:0]   o_acc
);

   logic [XLEN:0] sum;
   logic [XLEN:0] trial;

   // Shift-add or restoring-subtract step; trial MSB is the borrow of the subtract.
   always_comb begin
      sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opb};
      trial = i_acc[2*XLEN-1:XLEN-1] - {1'b0, i_opb};
      o_acc = i_acc;
      if (i_div) begin
         if (trial[XLEN]) begin
            o_acc = {i_acc[2*XLEN-2:0], 1'b0};
         end else begin
            o_acc = {trial[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
         end
      end else if (i_acc[0]) begin
         o_acc = {sum, i_acc[XLEN-1:1]};
      end else begin
         o_acc = {1'b0, i_acc[2*XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit, UNROLL steps per clock.
//
// state | meaning
// IDLE  | ready for a request; o_result holds the previous result
// CALC  | iterating the step chain, cnt_q groups remaining
// DONE  | o_valid high, o_result stable until i_ready
module muldiv
   import muldiv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [2:0]        i_op,
   input  logic [XLEN-1:0]   i_op1,
   input  logic [XLEN-1:0]   i_op2,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [XLEN-1:0]   o_result,
   output logic              o_busy
);

   localparam int N     = XLEN / UNROLL;
   localparam int CNT_W = $clog2(N + 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e        state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2:0]           op_q;
   logic [XLEN-1:0]      opb_q;
   logic [2*XLEN-1:0]    acc_q;
   logic                 neg_q;

   logic                 sgn1, sgn2, neg_in;
   logic [XLEN-1:0]      mag1, mag2;
   logic                 special;
   logic [XLEN-1:0]      special_res;
   logic [2*XLEN-1:0]    chain [0:UNROLL];
   logic [2*XLEN-1:0]    acc_fin;
   logic [2*XLEN-1:0]    prod;
   logic [XLEN-1:0]      quo, rem, fin;

   assign o_ready = (state_q == ST_IDLE);
   assign o_busy  = (state_q != ST_IDLE);

   // Operand magnitudes, result sign and divide special cases, decoded from the request.
   always_comb begin
      sgn1        = op1_signed(i_op) & i_op1[XLEN-1];
      sgn2        = op2_signed(i_op) & i_op2[XLEN-1];
      mag1        = sgn1 ? -i_op1 : i_op1;
      mag2        = sgn2 ? -i_op2 : i_op2;
      neg_in      = is_rem(i_op) ? sgn1 : (sgn1 ^ sgn2);
      special     = 1'b0;
      special_res = '0;
      if (is_div(i_op)) begin
         if (i_op2 == '0) begin
            special     = 1'b1;
            special_res = is_rem(i_op) ? i_op1 : '1;
         end else if (((i_op == MULDIV_DIV) || (i_op == MULDIV_REM)) &&
                      (i_op1 == MOST_NEG) && (i_op2 == '1)) begin
            special     = 1'b1;
            special_res = is_rem(i_op) ? '0 : i_op1;
         end
      end
   end

   assign chain[0] = acc_q;

   for (genvar g = 0; g < UNROLL; g++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
         .i_div (is_div(op_q)),
         .i_opb (opb_q),
         .i_acc (chain[g]),
         .o_acc (chain[g+1])
      );
   end

   assign acc_fin = chain[UNROLL];

   // Sign fixup and result selection applied to the output of the final step group.
   always_comb begin
      prod = neg_q ? -acc_fin : acc_fin;
      quo  = acc_fin[XLEN-1:0];
      rem  = acc_fin[2*XLEN-1:XLEN];
      case (op_q)
         MULDIV_MUL:                               fin = prod[XLEN-1:0];
         MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: fin = prod[2*XLEN-1:XLEN];
         MULDIV_DIV, MULDIV_DIVU:                  fin = neg_q ? -quo : quo;
         default:                                  fin = neg_q ? -rem : rem;
      endcase
   end

   // Control FSM with operand, accumulator and result registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         o_result <= '0;
         o_valid  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  op_q  <= i_op;
                  neg_q <= neg_in;
                  if (special) begin
                     o_result <= special_res;
                     o_valid  <= 1'b1;
                     state_q  <= ST_DONE;
                  end else begin
                     opb_q   <= is_div(i_op) ? mag2 : mag1;
                     acc_q   <= {{XLEN{1'b0}}, (is_div(i_op) ? mag1 : mag2)};
                     cnt_q   <= CNT_W'(N);
                     state_q <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               acc_q <= acc_fin;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  o_result <= fin;
                  o_valid  <= 1'b1;
                  state_q  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench: three configurations (32/1, 32/4, 64/2) driven one request at a time.
module tb_muldiv;
   import muldiv_pkg::*;

   typedef struct {
      logic [63:0] res;
      int          lat;
   } exp_t;

   typedef struct {
      int          d;
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  valid = '0;
   logic [2:0]  rdy_in = '1;
   logic [2:0]  op [3];
   logic [63:0] a [3];
   logic [63:0] b [3];
   wire  [2:0]  o_rdy, o_vld, o_bsy;
   wire  [31:0] res0, res1;
   wire  [63:0] res2;

   int vectors = 0;
   int miscompares = 0;
   exp_t sb[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   muldiv #(.XLEN(32), .UNROLL(1)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .o_ready(o_rdy[0]),
      .i_op(op[0]), .i_op1(a[0][31:0]), .i_op2(b[0][31:0]),
      .o_valid(o_vld[0]), .i_ready(rdy_in[0]), .o_result(res0), .o_busy(o_bsy[0]));

   muldiv #(.XLEN(32), .UNROLL(4)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .o_ready(o_rdy[1]),
      .i_op(op[1]), .i_op1(a[1][31:0]), .i_op2(b[1][31:0]),
      .o_valid(o_vld[1]), .i_ready(rdy_in[1]), .o_result(res1), .o_busy(o_bsy[1]));

   muldiv #(.XLEN(64), .UNROLL(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid[2]), .o_ready(o_rdy[2]),
      .i_op(op[2]), .i_op1(a[2]), .i_op2(b[2]),
      .o_valid(o_vld[2]), .i_ready(rdy_in[2]), .o_result(res2), .o_busy(o_bsy[2]));

   function automatic int w_of(int d);
      return (d == 2) ? 64 : 32;
   endfunction

   function automatic int lat_of(int d);
      case (d)
         0:       return 33;
         1:       return 9;
         default: return 33;
      endcase
   endfunction

   function automatic logic [63:0] msk(int w);
      return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic logic [63:0] res_of(int d);
      case (d)
         0:       return {32'b0, res0};
         1:       return {32'b0, res1};
         default: return res2;
      endcase
   endfunction

   function automatic void check(string nm, logic [63:0] got, logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endfunction

   // Reference model built on native wide arithmetic.
   function automatic logic [63:0] model(logic [2:0] o, logic [63:0] x0, logic [63:0] y0, int w);
      logic [63:0] m = msk(w);
      logic [63:0] x = x0 & m;
      logic [63:0] y = y0 & m;
      logic [63:0] mn = 64'h1 << (w - 1);
      logic signed [63:0] sx, sy;
      logic [127:0] ex, ey, p;
      sx = (w == 64) ? x : {{32{x[31]}}, x[31:0]};
      sy = (w == 64) ? y : {{32{y[31]}}, y[31:0]};
      ex = (o == MULDIV_MULHU) ? {64'b0, x} : {{64{sx[63]}}, sx};
      ey = (o == MULDIV_MULH || o == MULDIV_MUL) ? {{64{sy[63]}}, sy} : {64'b0, y};
      p  = ex * ey;
      case (o)
         MULDIV_MUL:  return p[63:0] & m;
         MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: return 64'(p >> w) & m;
         MULDIV_DIV: begin
            if (y == 0) return m;
            if (x == mn && y == m) return x;
            return 64'(sx / sy) & m;
         end
         MULDIV_DIVU: return (y == 0) ? m : (x / y) & m;
         MULDIV_REM: begin
            if (y == 0) return x;
            if (x == mn && y == m) return 64'h0;
            return 64'(sx % sy) & m;
         end
         default: return (y == 0) ? x : (x % y) & m;
      endcase
   endfunction

   function automatic int exp_lat(int d, logic [2:0] o, logic [63:0] x0, logic [63:0] y0);
      int w = w_of(d);
      logic [63:0] x = x0 & msk(w);
      logic [63:0] y = y0 & msk(w);
      if (o[2] && y == 0) return 1;
      if ((o == MULDIV_DIV || o == MULDIV_REM) && x == (64'h1 << (w - 1)) && y == msk(w)) return 1;
      return lat_of(d);
   endfunction

   function automatic logic [63:0] pick(int w);
      logic [63:0] v;
      case ($urandom_range(0, 7))
         0:       v = 64'h0;
         1:       v = 64'h1;
         2:       v = 64'hFFFF_FFFF_FFFF_FFFF;
         3:       v = 64'h1 << (w - 1);
         4:       v = 64'($urandom_range(0, 15));
         default: v = {$urandom, $urandom};
      endcase
      return v & msk(w);
   endfunction

   // Drive one request (called on a negedge) and push its expectation.
   task automatic issue(int d, logic [2:0] o, logic [63:0] x, logic [63:0] y, logic [63:0] e, int lat);
      int n = 0;
      exp_t ex;
      while (!o_rdy[d] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!o_rdy[d]) check($sformatf("ready_timeout_d%0d", d), 64'(o_rdy[d]), 64'h1);
      ex.res = e & msk(w_of(d));
      ex.lat = lat;
      sb.push_back(ex);
      valid[d] = 1'b1;
      op[d]    = o;
      a[d]     = x;
      b[d]     = y;
      @(posedge clk);
      @(negedge clk);
      valid[d] = 1'b0;
      a[d]     = {$urandom, $urandom};
      b[d]     = {$urandom, $urandom};
   endtask

   // Wait (bounded) for o_valid, counting edges from the accept edge inclusive.
   task automatic collect(int d, string nm);
      int lat = 1;
      exp_t ex;
      while (!o_vld[d] && lat < 200) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      if (sb.size() == 0) begin
         check({nm, "_sb_empty"}, 64'h1, 64'h0);
      end else begin
         ex = sb.pop_front();
         check({nm, "_result"}, res_of(d), ex.res);
         if (ex.lat > 0) check({nm, "_latency"}, 64'(lat), 64'(ex.lat));
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         op[i] = '0;
         a[i]  = '0;
         b[i]  = '0;
      end

      tbl.push_back('{0, MULDIV_MUL,    64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, 33});
      tbl.push_back('{0, MULDIV_MULH,   64'h80000000, 64'h80000000, 64'h40000000, 33});
      tbl.push_back('{0, MULDIV_MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33});
      tbl.push_back('{0, MULDIV_MULHSU, 64'hFFFFFFFF, 64'h2,        64'hFFFFFFFF, 33});
      tbl.push_back('{0, MULDIV_DIV,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 33});
      tbl.push_back('{0, MULDIV_REM,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 33});
      tbl.push_back('{0, MULDIV_DIVU,   64'h7,        64'h2,        64'h3,        33});
      tbl.push_back('{0, MULDIV_REMU,   64'h7,        64'h2,        64'h1,        33});
      tbl.push_back('{0, MULDIV_DIV,    64'h5,        64'h0,        64'hFFFFFFFF, 1});
      tbl.push_back('{0, MULDIV_REMU,   64'h5,        64'h0,        64'h5,        1});
      tbl.push_back('{0, MULDIV_DIV,    64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1});
      tbl.push_back('{0, MULDIV_REM,    64'h80000000, 64'hFFFFFFFF, 64'h0,        1});
      tbl.push_back('{1, MULDIV_MUL,    64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, 9});
      tbl.push_back('{1, MULDIV_DIV,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 9});
      tbl.push_back('{1, MULDIV_REMU,   64'h5,        64'h0,        64'h5,        1});
      tbl.push_back('{2, MULDIV_MULHU,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 33});
      tbl.push_back('{2, MULDIV_MUL,    64'hFFFFFFFFFFFFFFFD, 64'h5, 64'hFFFFFFFFFFFFFFF1, 33});
      tbl.push_back('{2, MULDIV_DIVU,   64'd100,      64'd7,        64'd14,       33});
      tbl.push_back('{2, MULDIV_DIV,    64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1});

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset_ready_d%0d", d), 64'(o_rdy[d]), 64'h1);
         check($sformatf("reset_valid_d%0d", d), 64'(o_vld[d]), 64'h0);
         check($sformatf("reset_busy_d%0d", d),  64'(o_bsy[d]), 64'h0);
         check($sformatf("reset_result_d%0d", d), res_of(d), 64'h0);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         issue(tbl[i].d, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);
         collect(tbl[i].d, $sformatf("vec%0d", i));
      end

      // Backpressure: result held in DONE for 5 cycles while a new request is offered.
      @(negedge clk);
      rdy_in[0] = 1'b0;
      issue(0, MULDIV_DIVU, 64'h7, 64'h2, 64'h3, 33);
      collect(0, "bp_first");
      for (int k = 0; k < 5; k++) begin
         valid[0] = 1'b1;
         op[0]    = MULDIV_MUL;
         a[0]     = 64'h3;
         b[0]     = 64'h4;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("bp_hold_result_%0d", k), res_of(0), 64'h3);
         check($sformatf("bp_hold_ready_%0d", k), 64'(o_rdy[0]), 64'h0);
         check($sformatf("bp_hold_valid_%0d", k), 64'(o_vld[0]), 64'h1);
      end
      rdy_in[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_idle_ready", 64'(o_rdy[0]), 64'h1);
      check("bp_idle_valid", 64'(o_vld[0]), 64'h0);
      check("bp_idle_result_held", res_of(0), 64'h3);
      sb.push_back('{64'hC, 33});
      @(posedge clk);
      @(negedge clk);
      valid[0] = 1'b0;
      check("bp_accepted_busy", 64'(o_bsy[0]), 64'h1);
      collect(0, "bp_second");

      // Reset ten cycles into CALC abandons the operation.
      @(negedge clk);
      @(negedge clk);
      valid[0] = 1'b1;
      op[0]    = MULDIV_MUL;
      a[0]     = 64'h5;
      b[0]     = 64'h6;
      @(posedge clk);
      @(negedge clk);
      valid[0] = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_ready", 64'(o_rdy[0]), 64'h1);
      check("midrst_valid", 64'(o_vld[0]), 64'h0);
      check("midrst_result", res_of(0), 64'h0);
      issue(0, MULDIV_MUL, 64'h3, 64'h4, 64'hC, 33);
      collect(0, "midrst_mul");

      // Random sweep against the reference model.
      for (int d = 0; d < 3; d++) begin
         int cnt = (d == 0) ? 500 : (d == 1) ? 1500 : 400;
         for (int i = 0; i < cnt; i++) begin
            logic [2:0]  o = 3'($urandom_range(0, 7));
            logic [63:0] x = pick(w_of(d));
            logic [63:0] y = pick(w_of(d));
            issue(d, o, x, y, model(o, x, y, w_of(d)), exp_lat(d, o, x, y));
            collect(d, $sformatf("rnd_d%0d_op%0d_%h_%h", d, o, x, y));
         end
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
